// File: rtl/img_mem_arbiter_pkg.sv
// Shared types and image constants for the image memory arbiter.
// Owner codes, FSM state encodings and read-tag layout live here.
package img_mem_arbiter_pkg;

  localparam int IMG_W      = 320;
  localparam int IMG_H      = 240;
  localparam int IMG_ADDR_W = 17;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_PROC = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SERVE_DISP = 2'd1,
    SERVE_PROC = 2'd2,
    PROC_WAIT  = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } tag_t;

endpackage

// File: rtl/img_mem_arbiter_if.sv
// Requester-side bus of the image memory arbiter: display read port and
// processing read/write port. The arbiter uses slave, requesters use master.
interface img_mem_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
);

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;

  logic              proc_req;
  logic              proc_we;
  logic [ADDR_W-1:0] proc_addr;
  logic [DATA_W-1:0] proc_wdata;
  logic              proc_gnt;
  logic [DATA_W-1:0] proc_rdata;
  logic              proc_rvalid;
  logic              proc_starved;

  modport master (
    output disp_req, disp_addr, proc_req, proc_we, proc_addr, proc_wdata,
    input  disp_data, disp_valid, proc_gnt, proc_rdata, proc_rvalid, proc_starved
  );

  modport slave (
    input  disp_req, disp_addr, proc_req, proc_we, proc_addr, proc_wdata,
    output disp_data, disp_valid, proc_gnt, proc_rdata, proc_rvalid, proc_starved
  );

endinterface

// File: rtl/img_mem_arbiter_tag_pipe.sv
// Shift register of {valid, owner} tags that tracks reads through the memory
// pipeline so each returning word can be routed to its requester.
module mem_tag_pipe
  import img_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stages [DEPTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stages[i] <= '0;
      end
    end else begin
      stages[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/img_mem_arbiter.sv
// Shares the single-port image memory between the real-time display reader
// (absolute priority) and the processing requester, with starvation flagging.
module img_mem_arbiter
  import img_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 2,
  parameter int STARVE_MAX = 1024,
  parameter int CNT_W      = 11
) (
  input  logic              clock,
  input  logic              reset,
  img_mem_arbiter_if.slave  bus,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  owner_t            owner;
  arb_state_t        state, state_next;
  logic [ADDR_W-1:0] last_addr;
  logic [CNT_W-1:0]  starve_cnt, starve_cnt_next;
  logic              starved;
  tag_t              tag_in, tag_out;
  logic              disp_hit, proc_hit;
  logic [DATA_W-1:0] disp_hold, proc_hold;

  always_comb begin
    owner = OWN_NONE;
    if (!reset) begin
      if (bus.disp_req)      owner = OWN_DISP;
      else if (bus.proc_req) owner = OWN_PROC;
    end
  end

  assign bus.proc_gnt = (owner == OWN_PROC);

  // Idle cycles keep the previous address so the memory sees no spurious change.
  always_comb begin
    mem_address = last_addr;
    mem_data    = '0;
    mem_wren    = 1'b0;
    case (owner)
      OWN_DISP: mem_address = bus.disp_addr;
      OWN_PROC: begin
        mem_address = bus.proc_addr;
        mem_data    = bus.proc_wdata;
        mem_wren    = bus.proc_we;
      end
      default: begin
        if (reset) mem_address = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) last_addr <= '0;
    else       last_addr <= mem_address;
  end

  always_comb begin
    tag_in.owner = owner;
    tag_in.valid = (owner == OWN_DISP) || ((owner == OWN_PROC) && !bus.proc_we);
  end

  mem_tag_pipe #(.DEPTH(RD_LATENCY)) u_tag_pipe (
    .clock   (clock),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign disp_hit = !reset && tag_out.valid && (tag_out.owner == OWN_DISP);
  assign proc_hit = !reset && tag_out.valid && (tag_out.owner == OWN_PROC);

  always_ff @(posedge clock) begin
    if (reset) begin
      disp_hold <= '0;
      proc_hold <= '0;
    end else begin
      if (disp_hit) disp_hold <= mem_q;
      if (proc_hit) proc_hold <= mem_q;
    end
  end

  assign bus.disp_valid  = disp_hit;
  assign bus.proc_rvalid = proc_hit;
  assign bus.disp_data   = reset ? '0 : (disp_hit ? mem_q : disp_hold);
  assign bus.proc_rdata  = reset ? '0 : (proc_hit ? mem_q : proc_hold);

  always_comb begin
    state_next = IDLE;
    case (owner)
      OWN_DISP: state_next = bus.proc_req ? PROC_WAIT : SERVE_DISP;
      OWN_PROC: state_next = SERVE_PROC;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // The streak restarts at 1 whenever the previous cycle was not a denial.
  always_comb begin
    starve_cnt_next = '0;
    if (state_next == PROC_WAIT) begin
      if (state != PROC_WAIT)            starve_cnt_next = CNT_W'(1);
      else if (starve_cnt == STARVE_LIM) starve_cnt_next = starve_cnt;
      else                               starve_cnt_next = starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= '0;
      starved    <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_next;
      starved    <= starved | (starve_cnt_next == STARVE_LIM);
    end
  end

  assign bus.proc_starved = starved;

endmodule

// File: tb/tb_img_mem_arbiter.sv
// Scoreboard bench for img_mem_arbiter with a latency-2 behavioural memory.
// The driver predicts responses from a shadow image; a monitor checks them.
module tb_img_mem_arbiter;

  localparam int ADDR_W   = 17;
  localparam int DATA_W   = 8;
  localparam int MEM_SIZE = 76800;

  typedef struct {
    int              cyc;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              clock = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q = '0;

  img_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  img_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(2), .STARVE_MAX(1024), .CNT_W(11)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .mem_q       (mem_q)
  );

  always #20 clock = ~clock;

  function automatic logic [DATA_W-1:0] init_val(input int a);
    return DATA_W'((a * 13 + 7) ^ (a >> 8));
  endfunction

  // Memory model: address register then output register, write-first.
  logic [DATA_W-1:0] mem [MEM_SIZE];
  logic [ADDR_W-1:0] mem_addr_r = '0;
  bit                mem_ready = 1'b0;

  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < MEM_SIZE; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else begin
      if (mem_wren) mem[mem_address] <= mem_data;
      mem_q <= mem[mem_addr_r];
    end
    mem_addr_r <= mem_address;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int   tests_run = 0;
  int   tests_failed = 0;
  logic [DATA_W-1:0] ref_mem [MEM_SIZE];
  exp_t disp_q[$];
  exp_t proc_q[$];
  int   streak = 0;
  logic starved_exp = 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of requests, check combinational grant/mux, update the model.
  task automatic apply_stimulus(input logic rst, input logic dreq, input int daddr,
                                input logic preq, input logic pwe, input int paddr,
                                input logic [DATA_W-1:0] pwd, output logic gnt);
    exp_t e;
    @(negedge clock);
    reset          = rst;
    bus.disp_req   = dreq;
    bus.disp_addr  = ADDR_W'(daddr);
    bus.proc_req   = preq;
    bus.proc_we    = pwe;
    bus.proc_addr  = ADDR_W'(paddr);
    bus.proc_wdata = pwd;
    #1;
    gnt = !rst && preq && !dreq;
    check_output("proc_gnt", 32'(bus.proc_gnt), 32'(gnt));
    check_output("mem_wren", 32'(mem_wren), 32'(gnt && pwe));
    if (!rst && dreq)  check_output("mem_address_disp", 32'(mem_address), 32'(daddr));
    else if (gnt)      check_output("mem_address_proc", 32'(mem_address), 32'(paddr));
    if (rst) begin
      disp_q.delete();
      proc_q.delete();
      streak = 0;
      starved_exp = 1'b0;
    end else begin
      if (dreq) begin
        e.cyc = cyc + 2; e.data = ref_mem[daddr];
        disp_q.push_back(e);
      end else if (preq) begin
        if (pwe) ref_mem[paddr] = pwd;
        else begin
          e.cyc = cyc + 2; e.data = ref_mem[paddr];
          proc_q.push_back(e);
        end
      end
      if (dreq && preq) streak++;
      else              streak = 0;
      if (streak >= 1024) starved_exp = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    logic g;
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, '0, g);
  endtask

  // Monitor: every cycle compare valid pulses, routed data and the sticky flag.
  exp_t mon_e;
  logic mon_exp;
  always @(posedge clock) begin
    #2;
    mon_exp = (disp_q.size() > 0) && (disp_q[0].cyc == cyc);
    check_output("disp_valid", 32'(bus.disp_valid), 32'(mon_exp));
    if (mon_exp) begin
      mon_e = disp_q.pop_front();
      if (bus.disp_valid) check_output("disp_data", 32'(bus.disp_data), 32'(mon_e.data));
    end
    mon_exp = (proc_q.size() > 0) && (proc_q[0].cyc == cyc);
    check_output("proc_rvalid", 32'(bus.proc_rvalid), 32'(mon_exp));
    if (mon_exp) begin
      mon_e = proc_q.pop_front();
      if (bus.proc_rvalid) check_output("proc_rdata", 32'(bus.proc_rdata), 32'(mon_e.data));
    end
    check_output("proc_starved", 32'(bus.proc_starved), 32'(starved_exp));
  end

  initial begin
    logic g;
    logic p_req, p_we, d_req;
    int   p_addr, d_addr;
    logic [DATA_W-1:0] p_wd;

    for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = init_val(i);
    reset = 1'b1;
    bus.disp_req = 1'b0; bus.disp_addr = '0;
    bus.proc_req = 1'b0; bus.proc_we = 1'b0; bus.proc_addr = '0; bus.proc_wdata = '0;

    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, '0, g);
    @(posedge clock); #2;
    check_output("reset_disp_data", 32'(bus.disp_data), 32'h0);
    check_output("reset_proc_rdata", 32'(bus.proc_rdata), 32'h0);
    check_output("reset_mem_wren", 32'(mem_wren), 32'h0);

    // Display burst: addresses 0..9 back to back.
    for (int a = 0; a < 10; a++) apply_stimulus(1'b0, 1'b1, a, 1'b0, 1'b0, 0, '0, g);
    idle(4);

    // Proc write then immediate read-back of the same pixel.
    apply_stimulus(1'b0, 1'b0, 0, 1'b1, 1'b1, 32'h100, 8'h2A, g);
    apply_stimulus(1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h100, '0, g);
    idle(4);

    // Contention: display wins, proc granted once display drops.
    apply_stimulus(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h200, '0, g);
    apply_stimulus(1'b0, 1'b1, 32'h11, 1'b1, 1'b0, 32'h200, '0, g);
    apply_stimulus(1'b0, 1'b0, 0,      1'b1, 1'b0, 32'h200, '0, g);
    idle(4);

    // Alternating display / proc reads.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) apply_stimulus(1'b0, 1'b1, 32'h40 + i, 1'b0, 1'b0, 0, '0, g);
      else            apply_stimulus(1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h80 + i, '0, g);
    end
    idle(4);

    // Randomised traffic on a small address window to provoke read-after-write.
    p_req = 1'b0; p_we = 1'b0; p_addr = 0; p_wd = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!p_req && ($urandom_range(0, 1) == 1)) begin
        p_req  = 1'b1;
        p_we   = 1'($urandom_range(0, 1));
        p_addr = int'($urandom_range(0, 63));
        p_wd   = DATA_W'($urandom);
      end
      d_req  = 1'($urandom_range(0, 1));
      d_addr = int'($urandom_range(0, 63));
      apply_stimulus(1'b0, d_req, d_addr, p_req, p_we, p_addr, p_wd, g);
      if (g) p_req = 1'b0;
      else if (p_req && ($urandom_range(0, 7) == 0)) p_req = 1'b0;
    end
    idle(4);

    // Reset with reads in flight: no pulses may emerge afterwards.
    apply_stimulus(1'b0, 1'b1, 5, 1'b0, 1'b0, 0, '0, g);
    apply_stimulus(1'b0, 1'b0, 0, 1'b1, 1'b0, 6, '0, g);
    apply_stimulus(1'b1, 1'b1, 7, 1'b1, 1'b0, 8, '0, g);
    apply_stimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, '0, g);
    idle(5);

    // Long denial: flag must rise after the 1024th consecutive denied cycle.
    for (int i = 0; i < 1100; i++) apply_stimulus(1'b0, 1'b1, i % 64, 1'b1, 1'b0, 32'h300, '0, g);
    apply_stimulus(1'b0, 1'b0, 0, 1'b1, 1'b0, 32'h300, '0, g);
    idle(4);
    check_output("starved_sticky", 32'(bus.proc_starved), 32'h1);

    apply_stimulus(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, '0, g);
    idle(4);
    check_output("starved_after_reset", 32'(bus.proc_starved), 32'h0);
    check_output("disp_queue_drained", 32'(disp_q.size()), 32'h0);
    check_output("proc_queue_drained", 32'(proc_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
